// File: rtl/key_loader.sv
// Serial key loader: shifts in a key plus an XOR-of-slices check field, then
// commits the key atomically to the key-gate outputs only when the check matches.
module key_loader #(
  parameter int KEY_XOR_W = 36,
  parameter int KEY_MUX_W = 4,
  parameter int CHK_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 key_clear,
  input  logic                 s_valid,
  input  logic                 s_bit,
  output logic                 s_ready,
  output logic [KEY_XOR_W-1:0] key_xor,
  output logic [KEY_MUX_W-1:0] key_mux,
  output logic                 key_loaded,
  output logic                 done,
  output logic                 error,
  output logic                 busy
);

  localparam int K        = KEY_XOR_W + KEY_MUX_W;
  localparam int FRAME_W  = K + CHK_W;
  localparam int CNT_W    = $clog2(FRAME_W + 1);
  localparam int N_SLICES = K / CHK_W;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ERR} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  // Key bits occupy [K-1:0], received check field sits in [FRAME_W-1:K].
  logic [FRAME_W-1:0] frame_reg;
  logic [CHK_W-1:0]   chk_expected;
  logic               accept;
  logic               last_bit;
  logic               chk_match;

  assign accept    = (state_reg == SHIFT) && s_valid;
  assign last_bit  = (cnt_reg == CNT_W'(FRAME_W - 1));
  assign chk_match = (frame_reg[K +: CHK_W] == chk_expected);
  assign s_ready   = (state_reg == SHIFT);
  assign busy      = (state_reg == SHIFT) || (state_reg == CHECK);

  always_comb begin
    chk_expected = '0;
    for (int j = 0; j < N_SLICES; j++) begin
      chk_expected = chk_expected ^ frame_reg[CHK_W*j +: CHK_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (key_clear) begin
      state_next = IDLE;
    end else if (load_start) begin
      state_next = SHIFT;
    end else begin
      case (state_reg)
        SHIFT:   if (accept && last_bit) state_next = CHECK;
        CHECK:   state_next = chk_match ? IDLE : ERR;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      frame_reg  <= '0;
      key_xor    <= '0;
      key_mux    <= '0;
      key_loaded <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (key_clear) begin
        cnt_reg    <= '0;
        frame_reg  <= '0;
        key_xor    <= '0;
        key_mux    <= '0;
        key_loaded <= 1'b0;
        error      <= 1'b0;
      end else if (load_start) begin
        cnt_reg   <= '0;
        frame_reg <= '0;
        error     <= 1'b0;
      end else if (accept) begin
        for (int i = 0; i < FRAME_W; i++) begin
          if (cnt_reg == CNT_W'(i)) frame_reg[i] <= s_bit;
        end
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (state_reg == CHECK) begin
        // Commit happens in one edge so a new key never appears partially.
        if (chk_match) begin
          key_xor    <= frame_reg[KEY_XOR_W-1:0];
          key_mux    <= frame_reg[K-1:KEY_XOR_W];
          key_loaded <= 1'b1;
          done       <= 1'b1;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: good/bad check loads, abort, random stalls,
// key_clear priority and asynchronous reset mid-load.
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst_n, load_start, key_clear, s_valid, s_bit;
  logic        s_ready, key_loaded, done, error, busy;
  logic [35:0] key_xor;
  logic [3:0]  key_mux;

  int checks   = 0;
  int failures = 0;

  localparam logic [35:0] ONES_X = 36'hF_FFFF_FFFF;
  localparam logic [35:0] K1_X   = 36'h2_3456_789A;

  logic [47:0] f_good, f_bad, f_ones, f_one, f_junk;

  always #5 clk = ~clk;

  key_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_clear(key_clear),
    .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready), .key_xor(key_xor),
    .key_mux(key_mux), .key_loaded(key_loaded), .done(done), .error(error),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Offers nbits of frame LSB first; returns on the negedge after the last accepting edge.
  task automatic send_bits(input logic [47:0] frame, input int nbits, input bit rand_valid);
    int idx = 0;
    int cycles = 0;
    while (idx < nbits) begin
      if (cycles >= 2000) begin
        check("send_budget", 64'(idx), 64'(nbits));
        break;
      end
      s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_bit   = s_valid ? frame[idx] : 1'($urandom_range(0, 1));
      if (s_valid && !s_ready) check("s_ready_bit", 64'(s_ready), 64'd1);
      @(negedge clk);
      if (s_valid) idx++;
      cycles++;
    end
    s_valid = 1'b0;
  endtask

  task automatic expect_commit(input logic [35:0] xr, input logic [3:0] mx,
                               input logic [35:0] prev_x, input logic prev_loaded);
    check("check_done_low", 64'(done), 64'd0);
    check("check_busy", 64'(busy), 64'd1);
    check("check_sready", 64'(s_ready), 64'd0);
    check("check_hold_xor", 64'(key_xor), 64'(prev_x));
    check("check_hold_loaded", 64'(key_loaded), 64'(prev_loaded));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("key_xor", 64'(key_xor), 64'(xr));
    check("key_mux", 64'(key_mux), 64'(mx));
    check("key_loaded", 64'(key_loaded), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
    check("error_clear", 64'(error), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("key_xor_hold", 64'(key_xor), 64'(xr));
  endtask

  task automatic expect_error(input logic [35:0] prev_x, input logic [3:0] prev_m,
                              input logic prev_loaded);
    check("err_check_done", 64'(done), 64'd0);
    @(negedge clk);
    check("err_flag", 64'(error), 64'd1);
    check("err_done", 64'(done), 64'd0);
    check("err_xor_hold", 64'(key_xor), 64'(prev_x));
    check("err_mux_hold", 64'(key_mux), 64'(prev_m));
    check("err_loaded_hold", 64'(key_loaded), 64'(prev_loaded));
    check("err_busy", 64'(busy), 64'd0);
    s_valid = 1'b1;
    s_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("err_sready", 64'(s_ready), 64'd0);
      @(negedge clk);
      check("err_no_done", 64'(done), 64'd0);
    end
    s_valid = 1'b0;
    check("err_sticky", 64'(error), 64'd1);
    check("err_xor_after_bits", 64'(key_xor), 64'(prev_x));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    f_good = {8'h92, 40'h12_3456_789A};
    f_bad  = {8'h93, 40'h12_3456_789A};
    f_ones = {8'hFF, 40'hFF_FFFF_FFFF};
    f_one  = {8'h01, 40'h00_0000_0001};
    f_junk = {8'h00, 40'hA5_A5A5_A5A5};
    rst_n = 1'b0; load_start = 1'b0; key_clear = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
    #1;
    check("rst_xor", 64'(key_xor), 64'd0);
    check("rst_mux", 64'(key_mux), 64'd0);
    check("rst_loaded", 64'(key_loaded), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sready", 64'(s_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bad check from reset: outputs stay zero, ERR entered
    start_load();
    check("shift_busy", 64'(busy), 64'd1);
    send_bits(f_bad, 48, 1'b0);
    expect_error(36'd0, 4'd0, 1'b0);

    // Good load straight out of ERR
    start_load();
    check("err_cleared_on_load", 64'(error), 64'd0);
    check("busy_after_err", 64'(busy), 64'd1);
    send_bits(f_good, 48, 1'b0);
    expect_commit(K1_X, 4'h1, 36'd0, 1'b0);

    // All-ones commit, aborted load, then key = 1
    start_load();
    send_bits(f_ones, 48, 1'b0);
    expect_commit(ONES_X, 4'hF, K1_X, 1'b1);
    start_load();
    send_bits(f_junk, 20, 1'b0);
    check("abort_mid_xor", 64'(key_xor), 64'(ONES_X));
    check("abort_mid_mux", 64'(key_mux), 64'hF);
    start_load();
    send_bits(f_one, 48, 1'b0);
    expect_commit(36'h1, 4'h0, ONES_X, 1'b1);

    // Random s_valid gaps
    start_load();
    send_bits(f_good, 48, 1'b1);
    expect_commit(K1_X, 4'h1, 36'h1, 1'b1);

    // key_clear beats simultaneous load_start
    key_clear = 1'b1;
    load_start = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    load_start = 1'b0;
    check("clr_xor", 64'(key_xor), 64'd0);
    check("clr_mux", 64'(key_mux), 64'd0);
    check("clr_loaded", 64'(key_loaded), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_sready", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("clr_stays_idle", 64'(busy), 64'd0);

    // key_clear mid-SHIFT
    start_load();
    send_bits(f_ones, 48, 1'b0);
    expect_commit(ONES_X, 4'hF, 36'd0, 1'b0);
    start_load();
    send_bits(f_good, 10, 1'b0);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    check("clr_shift_xor", 64'(key_xor), 64'd0);
    check("clr_shift_mux", 64'(key_mux), 64'd0);
    check("clr_shift_loaded", 64'(key_loaded), 64'd0);
    check("clr_shift_busy", 64'(busy), 64'd0);
    check("clr_shift_sready", 64'(s_ready), 64'd0);

    // Asynchronous reset mid-SHIFT
    start_load();
    send_bits(f_one, 48, 1'b0);
    expect_commit(36'h1, 4'h0, 36'd0, 1'b0);
    start_load();
    send_bits(f_good, 15, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_xor", 64'(key_xor), 64'd0);
    check("arst_loaded", 64'(key_loaded), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_sready", 64'(s_ready), 64'd0);
    check("arst_error", 64'(error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_waits", 64'(busy), 64'd0);
    start_load();
    send_bits(f_good, 48, 1'b0);
    expect_commit(K1_X, 4'h1, 36'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
